// File: rtl/de_selector_1n.sv
// rtl/de_selector_1n.sv - registered 1-to-N demux, direct or round-robin target; DE_SELECTOR_HOLD_EN keeps non-target fields
module de_selector_1n #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 1
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic [DATA_W-1:0]             iC,
    input  logic                          iValid,
    input  logic                          iMode,
    input  logic [SEL_W-1:0]              iS,
    output logic [(2**SEL_W)*DATA_W-1:0]  oZ,
    output logic [(2**SEL_W)-1:0]         oValid,
    output logic [SEL_W-1:0]              oCh,
    output logic                          oWrap
);

    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] target;

    assign target = iMode ? cnt : iS;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oZ     <= '1;
            oValid <= '0;
            oCh    <= '0;
            oWrap  <= 1'b0;
            cnt    <= '0;
        end else begin
            oValid <= '0;
            oWrap  <= 1'b0;
`ifndef DE_SELECTOR_HOLD_EN
            oZ     <= '1;
`endif
            if (iValid) begin
                oZ[target*DATA_W +: DATA_W] <= iC;
                oValid[target]              <= 1'b1;
                oCh                         <= target;
                // Only scan transfers move the counter; all-ones cnt is channel N-1.
                if (iMode) begin
                    cnt   <= cnt + 1'b1;
                    oWrap <= &cnt;
                end
            end
        end
    end

endmodule
